// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch PC, imem request issue, instruction queue and IF/ID register (optional FETCH_PERF_EN counters)
module fetch_queue_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  InstrValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_redirects,
    output logic [31:0]           perf_bubbles
`endif
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         outstanding_next;
    logic [CW-1:0]         drop;
    logic [CW-1:0]         q_cnt;
    logic [CW-1:0]         credit_used;

    // PCs of requests in flight, captured at accept and consumed by responses in order
    logic [DATA_WIDTH-1:0] pend_pc [QUEUE_DEPTH];
    logic [PW-1:0]         pend_wr;
    logic [PW-1:0]         pend_rd;

    // returned instructions waiting for decode, paired with their PCs
    logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [PW-1:0]         q_wr;
    logic [PW-1:0]         q_rd;

    logic bubble_load;
    logic pop;
    logic push;
    logic accept;

    // Issue and queue control; the slot freed by this cycle's pop counts as available credit
    always_comb begin
        bubble_load      = FlushD || PCSrcE;
        pop              = !bubble_load && !StallD && (q_cnt != '0);
        push             = imem_rsp_valid && (drop == '0) && !PCSrcE;
        credit_used      = outstanding + q_cnt - CW'(pop);
        imem_req_valid   = !rst && !StallF && !PCSrcE && (credit_used < DEPTH_C);
        imem_req_addr    = pc;
        accept           = imem_req_valid && imem_req_ready;
        outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    end

    // PC register: redirect wins, otherwise advance on each accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (PCSrcE) begin
            pc <= PCTargetE;
        end else if (accept) begin
            pc <= pc + DATA_WIDTH'(4);
        end
    end

    // In-flight and drop counters; a redirect marks everything still in flight for discard
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (PCSrcE) begin
                drop <= outstanding_next;
            end else if (imem_rsp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
        end
    end

    // Pointer bookkeeping for the pending-PC list and the instruction queue
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wr <= '0;
            pend_rd <= '0;
            q_wr    <= '0;
            q_rd    <= '0;
            q_cnt   <= '0;
        end else begin
            if (accept) begin
                pend_wr <= pend_wr + PW'(1);
            end
            if (imem_rsp_valid) begin
                pend_rd <= pend_rd + PW'(1);
            end
            if (PCSrcE) begin
                q_wr  <= '0;
                q_rd  <= '0;
                q_cnt <= '0;
            end else begin
                if (push) begin
                    q_wr <= q_wr + PW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PW'(1);
                end
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage writes for both queues; contents are qualified by the pointers above
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_pc[pend_wr] <= pc;
        end
        if (push) begin
            q_instr[q_wr] <= imem_rsp_data;
            q_pc[q_wr]    <= pend_pc[pend_rd];
        end
    end

    // IF/ID register: bubble on flush or redirect, hold on stall, else pop head or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD      <= NOP_INSTR;
            PCD         <= '0;
            PCPlus4D    <= DATA_WIDTH'(4);
            InstrValidD <= 1'b0;
        end else if (bubble_load) begin
            InstrD      <= NOP_INSTR;
            InstrValidD <= 1'b0;
        end else if (!StallD) begin
            if (pop) begin
                InstrD      <= q_instr[q_rd];
                PCD         <= q_pc[q_rd];
                PCPlus4D    <= q_pc[q_rd] + DATA_WIDTH'(4);
                InstrValidD <= 1'b1;
            end else begin
                InstrD      <= NOP_INSTR;
                InstrValidD <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters for redirects and bubbles loaded into IF/ID
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_redirects <= '0;
            perf_bubbles   <= '0;
        end else begin
            if (PCSrcE && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if ((bubble_load || (!StallD && (q_cnt == '0))) && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
